// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
// Defining LOADER_CHECKSUM_EN adds the CHECK state to the state enum.
package loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects accepted stream bytes into little-endian words and flags the
// cycle in which the last byte of a word arrives, together with the full word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    output logic                  word_done,
    output logic [DATA_WIDTH-1:0] word_data
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    // Lane 0 holds the oldest byte; new bytes enter at the top lane and shift down.
    logic [BYTES_PER_WORD-2:0][7:0] lane_reg;
    logic [BYTES_PER_WORD-2:0][7:0] lane_next;
    logic [CNT_W-1:0]               byte_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            if (gi == BYTES_PER_WORD - 2) begin : g_top
                assign lane_next[gi] = byte_data;
            end else begin : g_mid
                assign lane_next[gi] = lane_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (byte_en) begin
            if (byte_cnt_reg == LAST_BYTE) begin
                lane_reg     <= '0;
                byte_cnt_reg <= '0;
            end else begin
                lane_reg     <= lane_next;
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
        end
    end

    assign word_done = byte_en && (byte_cnt_reg == LAST_BYTE);
    assign word_data = DATA_WIDTH'({byte_data, lane_reg});

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory
// while holding the CPU. Optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t                  state_reg, state_next;
    logic [15:0]             len_reg, len_next;
    logic [ADDR_WIDTH-1:0]   word_idx_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic                    accept;
    logic                    asm_clear;
    logic                    asm_en;
    logic                    word_done;
    logic [DATA_WIDTH-1:0]   asm_word;
    logic [16:0]             len_full;
    logic                    last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              xor_reg;
`endif

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .byte_en   (asm_en),
        .byte_data (byte_data),
        .word_done (word_done),
        .word_data (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            word_idx_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            mem_we_reg <= word_done;
            if (asm_clear) begin
                word_idx_reg <= '0;
            end else if (word_done) begin
                word_idx_reg  <= word_idx_reg + 1'b1;
                mem_addr_reg  <= word_idx_reg;
                mem_wdata_reg <= asm_word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over length and data bytes; the checksum byte itself is excluded.
    always_ff @(posedge clk) begin
        if (rst || asm_clear) begin
            xor_reg <= '0;
        end else if (accept && state_reg != ST_CHECK) begin
            xor_reg <= xor_reg ^ byte_data;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        asm_clear  = 1'b0;
        byte_ready = 1'b0;
        len_full   = {1'b0, byte_data, len_reg[7:0]};
        last_word  = (17'(word_idx_reg) == ({1'b0, len_reg} - 17'd1));

        case (state_reg)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:                      byte_ready = 1'b1;
`endif
            default:                       byte_ready = 1'b0;
        endcase

        accept = byte_valid && byte_ready;
        asm_en = accept && (state_reg == ST_DATA);

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN_LO;
                    len_next   = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next   = {8'h00, byte_data};
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_next = len_full[15:0];
                    if (len_full > DEPTH) begin
                        state_next = ST_ERROR;
                    end else if (len_full == 17'd0) begin
                        state_next = ST_AFTER_DATA;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done && last_word) begin
                    state_next = ST_AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_next = (byte_data == xor_reg) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_hold  = (state_reg != ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign error     = (state_reg == ST_ERROR);

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DATA_WIDTH SHALL default 32: instruction word width, fixed at 4 bytes.
REQ-002 Parameter ADDR_WIDTH SHALL default 8: instruction-memory word-index width, giving a depth of 2^ADDR_WIDTH words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a pulse that begins a load; honoured only in IDLE, DONE or ERROR.
REQ-006 byte_valid  input  1  SHALL indicate that byte_data carries a valid stream byte.
REQ-007 byte_data  input  8  SHALL carry the stream byte.
REQ-008 byte_ready  output  1  SHALL indicate that the loader accepts a byte this cycle.
REQ-009 mem_we  output  1  SHALL be the instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_WIDTH  SHALL be the word index being written.
REQ-011 mem_wdata  output  DATA_WIDTH  SHALL be the assembled instruction word.
REQ-012 cpu_hold  output  1  SHALL hold the CPU (PC and register writes) while high.
REQ-013 done  output  1  SHALL be high while in DONE.
REQ-014 error  output  1  SHALL be high while in ERROR.

Function
REQ-015 A byte SHALL transfer on any cycle where byte_valid && byte_ready; no other byte is consumed.
REQ-016 Stream format SHALL be LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, little-endian (first byte maps to bits [7:0]).
REQ-017 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK (macro only), DONE, ERROR.
REQ-018 byte_ready SHALL be high in LEN_LO, LEN_HI, DATA and CHECK, and low in all other states.
REQ-019 From IDLE/DONE/ERROR, start SHALL move to LEN_LO; a start pulse in any other state SHALL be ignored.
REQ-020 After LEN_HI: if N > 2^ADDR_WIDTH go to ERROR; if N == 0 go to DONE (CHECK when the macro is enabled); otherwise go to DATA.
REQ-021 On acceptance of the 4th byte of a word, mem_we SHALL pulse high exactly one cycle later, with mem_addr = word index (starting at 0, +1 per word) and mem_wdata = the assembled word.
REQ-022 After writing word N-1, the FSM SHALL leave DATA in the same cycle the 4th byte is accepted, going to DONE (CHECK when the macro is enabled).
REQ-023 mem_we SHALL be low in all cycles other than the pulses defined in REQ-021.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we is low.
REQ-025 cpu_hold SHALL be high in every state except DONE.
REQ-026 Gaps of any length in byte_valid SHALL NOT alter state, counters or partial words.
REQ-027 A restart from DONE/ERROR SHALL clear the word index, the byte counter and the partial word.

Reset
REQ-028 rst SHALL take priority over all inputs, and the following values SHALL be seen in the cycle after rst is sampled high: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, all counters 0.
REQ-029 rst asserted mid-load SHALL abort the load with no further mem_we; words already written SHALL remain in memory.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, one checksum byte SHALL follow the data: the XOR of every LEN and data byte. CHECK SHALL accept it, then go to DONE on a match or to ERROR on a mismatch.
REQ-031 With LOADER_CHECKSUM_EN undefined, the CHECK state and the XOR register SHALL be absent, and DATA SHALL go directly to DONE.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum typedef, the LEN_BYTES=2 constant and the BYTES_PER_WORD=4 constant.
REQ-033 Sub-module word_assembler SHALL shift in accepted bytes and flag word-complete with the 4-byte little-endian word; instr_loader SHALL instantiate it once.

Verification
REQ-034 Reset, then start with stream 02 00, 13 05 50 00, 93 05 a0 00 -> mem_we pulses: addr 0 data 0x00500513, then addr 1 data 0x00a00593; done=1; cpu_hold=0.
REQ-035 Stream 00 00 -> DONE reached with no mem_we pulse (macro on: checksum 00 required).
REQ-036 With ADDR_WIDTH=8, stream 01 01 (N=257) -> ERROR, error=1, cpu_hold=1, no mem_we.
REQ-037 Random byte_valid gaps plus an extra start pulse during DATA -> identical writes to REQ-034; start ignored.
REQ-038 rst after the 2nd byte of word 1 -> IDLE, no further mem_we; a new start reloads from addr 0.
REQ-039 Macro on, stream 01 00 13 05 50 00 with checksum 0x47 -> DONE; same stream with checksum 0x46 -> ERROR.
